i2c_slave_reg_ctrl: RTL
=======================

// Module: i2c_slave_reg_ctrl
// PURPOSE
//  Register-access controller on the parallel side of the I2C slave. It turns the byte stream into register-bus operations.
//  - First data byte after a write-address match = register pointer; later bytes are writes at the pointer, which auto-increments.
//  - Read phases fetch from the pointer and load the slave's transmit byte, one fetch per byte the slave requests.
//  - The pointer survives STOP and repeated-START, so the combined format (write ptr, Sr, read burst) works.
// PARAMETERS
//  ADDR_W    8   register pointer width; the pointer space is 2**ADDR_W entries
//  AUTO_INC  1   1: increment the pointer after every data write and every read fetch; 0: pointer is static
//  IDLE_DATA 8'hFF  byte loaded to the slave on a tx request made while a fetch is already in flight
// PORTS
//  clk            in   1       clock
//  rst_n          in   1       reset, asynchronous, active-low
//  slv_flag_start in   1       1-cycle pulse: START detected
//  slv_flag_restart in 1       1-cycle pulse: repeated START detected
//  slv_flag_stop  in   1       1-cycle pulse: STOP detected
//  slv_hitar      in   1       level: the address matched in this transaction
//  slv_read_data  in   8       byte received from the master
//  slv_read_en    in   1       1-cycle pulse: slv_read_data is valid
//  slv_tx_req     in   1       1-cycle pulse from the slave: a read-address ACK occurred, or the master ACKed a read byte; next byte needed
//  slv_write_data out  8       next byte for the slave to transmit
//  slv_write_en   out  1       1-cycle pulse: load slv_write_data into the slave
//  reg_addr       out  ADDR_W  register bus address (equals the pointer)
//  reg_wdata      out  8       register write data
//  reg_wr         out  1       1-cycle register write strobe
//  reg_rd         out  1       1-cycle register read strobe; reg_rdata is valid on the next cycle
//  reg_rdata      in   8       register read data
//  busy           out  1       high while the FSM is not IDLE
//  ovr_err        out  1       sticky: tx_req arrived during a fetch; cleared by the next START
// BEHAVIOUR
//  Reset values: all outputs 0, except slv_write_data = 8'hFF. Pointer = 0. State = IDLE.
//  State transitions:
//  - IDLE -> PTR on slv_flag_start.
//  - PTR, first slv_read_en with slv_hitar=1: pointer <= slv_read_data[ADDR_W-1:0]; -> WDATA. No reg_wr for this byte.
//  - WDATA, each slv_read_en: reg_wr=1, reg_wdata=byte, reg_addr=pointer in the same cycle; pointer+1 on the next cycle if AUTO_INC.
//  - PTR/WDATA/IDLE, slv_tx_req: -> FETCH.
//    - FETCH (1 cycle): reg_rd=1 at the pointer.
//    - -> LOAD: slv_write_data <= reg_rdata; slv_write_en=1 for one cycle; pointer+1 if AUTO_INC; -> RDWAIT.
//    - Latency: tx_req at cycle N -> reg_rd at N+1 -> slv_write_en at N+2.
//  - RDWAIT, slv_tx_req: -> FETCH again, for a sequential read.
//  - Any state, slv_flag_restart: -> PTR. The pointer is kept. An in-flight FETCH/LOAD completes first; the restart is queued for 1 pending event.
//  - Any state, slv_flag_stop: -> IDLE after any in-flight FETCH/LOAD completes.
//  - PTR/WDATA: bytes arriving while slv_hitar=0 are ignored (no pointer update, no reg_wr).
//  Pointer arithmetic: ADDR_W-bit unsigned, wraps (2**ADDR_W-1)+1 -> 0. Pointer-byte bits above ADDR_W are discarded.
//  Boundary conditions:
//  - slv_read_en and slv_flag_stop in the same cycle: the write is performed, then the FSM goes to IDLE.
//  - slv_tx_req during FETCH/LOAD: request dropped; ovr_err <= 1; slv_write_data <= IDLE_DATA with a write_en pulse after the current load.
//  - slv_flag_start while not IDLE: treated as a restart (-> PTR); ovr_err cleared.
//  - reg_wr and reg_rd are never high in the same cycle. A write arriving in FETCH is stalled 1 cycle (1-entry holding reg).
//  - rst_n asserted mid-transaction: immediate return to reset values; strobes drop asynchronously.
// STRUCTURE
//  Shared package i2c_pkg:
//  - state localparams IDLE/PTR/WDATA/FETCH/LOAD/RDWAIT (3-bit encoding)
//  - default IDLE_DATA
//  Single flat module, no sub-module. The 1-entry write holding register stays inline.
// TESTING
//  1. START, ptr 0x10, data 0xA5,0x5A, STOP -> reg_wr at 0x10=0xA5 and 0x11=0x5A; pointer ends 0x12; busy low after STOP.
//  2. START, ptr 0x20, Sr, 3 tx_req (regs hold 0x01,0x02,0x03) -> write_en N+2 after each req; data 0x01,0x02,0x03; pointer 0x23.
//  3. ADDR_W=8, ptr 0xFF, write 0x11,0x22 -> writes at 0xFF then 0x00; wrap verified.
//  4. tx_req pulsed on 2 consecutive cycles -> single reg_rd; ovr_err=1; second load is 0xFF; next START clears ovr_err.
//  5. slv_hitar=0 with bytes 0x33,0x44 -> no reg_wr; pointer unchanged; slv_read_en+stop same cycle -> write done, state IDLE.
//  6. rst_n low during LOAD -> write_en/reg_rd drop immediately; pointer 0; slv_write_data 0xFF.

Source files
------------

// File: rtl/i2c_pkg.sv
// Package: i2c_pkg
// Purpose: shared definitions for the I2C slave register-access controller.
//          Holds the FSM state encoding and the default filler byte that is
//          sent to the slave when a read request cannot be serviced.
// Contents:
//    state_t            3-bit FSM state encoding
//    IDLE_DATA_DEFAULT  default byte loaded on an overrun request
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PTR    = 3'd1,
      WDATA  = 3'd2,
      FETCH  = 3'd3,
      LOAD   = 3'd4,
      RDWAIT = 3'd5
   } state_t;

   localparam logic [7:0] IDLE_DATA_DEFAULT = 8'hFF;

endpackage

// File: rtl/i2c_slave_reg_ctrl.sv
// Module: i2c_slave_reg_ctrl
// Purpose: turns the byte stream of an I2C slave into register-bus accesses.
//          The first byte after a write-address match sets the register
//          pointer, later bytes are written at the pointer. Read requests
//          fetch from the pointer and hand the byte to the slave. The pointer
//          survives STOP and repeated START so combined transfers work.
// Ports:
//    clk, rst_n                 clock, asynchronous active-low reset
//    slv_flag_start/restart/stop  1-cycle bus condition pulses
//    slv_hitar                  address matched in this transaction
//    slv_read_data, slv_read_en byte received from the master
//    slv_tx_req                 slave needs its next transmit byte
//    slv_write_data, slv_write_en  byte handed to the slave
//    reg_addr, reg_wdata, reg_wr, reg_rd, reg_rdata  register bus
//    busy                       FSM not idle
//    ovr_err                    sticky: request arrived during a fetch
module i2c_slave_reg_ctrl
   import i2c_pkg::*;
#(
   parameter int         ADDR_W    = 8,
   parameter bit         AUTO_INC  = 1'b1,
   parameter logic [7:0] IDLE_DATA = IDLE_DATA_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              slv_flag_start,
   input  logic              slv_flag_restart,
   input  logic              slv_flag_stop,
   input  logic              slv_hitar,
   input  logic [7:0]        slv_read_data,
   input  logic              slv_read_en,
   input  logic              slv_tx_req,
   output logic [7:0]        slv_write_data,
   output logic              slv_write_en,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [7:0]        reg_rdata,
   output logic              busy,
   output logic              ovr_err
);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [7:0]        tx_hold;
   logic [7:0]        wr_hold;
   logic              wr_pend;
   logic              idle_pend;
   logic              pend_restart;
   logic              pend_stop;

   logic              in_read;
   logic              ptr_byte;
   logic              data_byte;
   logic              start_fetch;
   logic              wr_issue;
   logic              hold_load;
   logic              evt_restart;
   logic              ovr_hit;
   logic              load_done;
   logic              idle_fill;
   logic [1:0]        ptr_step;

   // Decode of this cycle's events. A write that would collide with the
   // read strobe of a new fetch is parked in the holding register and
   // issued on the following cycle, so reg_wr and reg_rd never overlap.
   always_comb begin
      in_read     = (state == FETCH) || (state == LOAD);
      ptr_byte    = slv_read_en && slv_hitar && (state == PTR);
      data_byte   = slv_read_en && slv_hitar && (state == WDATA);
      start_fetch = slv_tx_req && !in_read;
      wr_issue    = (wr_pend || data_byte) && !start_fetch;
      hold_load   = data_byte && (start_fetch || wr_pend);
      evt_restart = slv_flag_start || slv_flag_restart;
      ovr_hit     = slv_tx_req && in_read;
      load_done   = (state == LOAD);
      idle_fill   = load_done && (idle_pend || slv_tx_req);
      ptr_step    = 2'd0;
      if (AUTO_INC) begin
         ptr_step = {1'b0, reg_wr} + {1'b0, load_done};
      end
   end

   // During LOAD the freshly read byte is passed straight through so the
   // slave sees it in the same cycle as the write_en pulse.
   assign slv_write_data = (state == LOAD) ? reg_rdata : tx_hold;
   assign reg_addr       = ptr;
   assign busy           = (state != IDLE);

   // Main FSM with registered strobes. The pointer advances one cycle after
   // each write strobe so reg_addr is stable while reg_wr is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= '0;
         tx_hold      <= 8'hFF;
         wr_hold      <= 8'h00;
         wr_pend      <= 1'b0;
         idle_pend    <= 1'b0;
         pend_restart <= 1'b0;
         pend_stop    <= 1'b0;
         slv_write_en <= 1'b0;
         reg_wdata    <= 8'h00;
         reg_wr       <= 1'b0;
         reg_rd       <= 1'b0;
         ovr_err      <= 1'b0;
      end else begin
         reg_wr <= wr_issue;
         if (wr_issue) begin
            reg_wdata <= wr_pend ? wr_hold : slv_read_data;
         end
         if (hold_load) begin
            wr_hold <= slv_read_data;
            wr_pend <= 1'b1;
         end else if (wr_issue) begin
            wr_pend <= 1'b0;
         end

         reg_rd       <= start_fetch;
         slv_write_en <= (state == FETCH) || idle_fill;

         if (ptr_byte) begin
            ptr <= slv_read_data[ADDR_W-1:0];
         end else begin
            ptr <= ptr + ADDR_W'(ptr_step);
         end

         if (ovr_hit) begin
            ovr_err <= 1'b1;
         end else if (slv_flag_start) begin
            ovr_err <= 1'b0;
         end

         // A request during FETCH is dropped; the slave instead receives
         // the filler byte right after the current load.
         if ((state == FETCH) && slv_tx_req) begin
            idle_pend <= 1'b1;
         end else if (load_done) begin
            idle_pend <= 1'b0;
         end

         if (load_done) begin
            tx_hold <= idle_fill ? IDLE_DATA : reg_rdata;
         end

         case (state)
            IDLE, PTR, WDATA, RDWAIT: begin
               if (start_fetch) begin
                  state        <= FETCH;
                  pend_restart <= evt_restart;
                  pend_stop    <= slv_flag_stop && !evt_restart;
               end else if (slv_flag_stop) begin
                  state <= IDLE;
               end else if (evt_restart) begin
                  state <= PTR;
               end else if (ptr_byte) begin
                  state <= WDATA;
               end
            end
            FETCH: begin
               state <= LOAD;
               if (evt_restart) begin
                  pend_restart <= 1'b1;
                  pend_stop    <= 1'b0;
               end else if (slv_flag_stop) begin
                  pend_restart <= 1'b0;
                  pend_stop    <= 1'b1;
               end
            end
            LOAD: begin
               if (evt_restart) begin
                  state <= PTR;
               end else if (slv_flag_stop) begin
                  state <= IDLE;
               end else if (pend_restart) begin
                  state <= PTR;
               end else if (pend_stop) begin
                  state <= IDLE;
               end else begin
                  state <= RDWAIT;
               end
               pend_restart <= 1'b0;
               pend_stop    <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
